// File: rtl/seg7_sequence_reader_if.sv
// ============================================================================
// Module   : seg7_sequence_reader_if
// Brief    : Tiny Tapeout pin bundle between a 7-segment sender and the reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg7_sequence_reader_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (
      output ena,
      output ui_in,
      output uio_in,
      input  uo_out,
      input  uio_out,
      input  uio_oe
   );

   modport slave (
      input  ena,
      input  ui_in,
      input  uio_in,
      output uo_out,
      output uio_out,
      output uio_oe
   );
endinterface

`default_nettype wire

// File: rtl/seg7_sequence_reader.sv
// ============================================================================
// Module   : seg7_sequence_reader
// Brief    : Samples a 7-segment bus on each advance strobe, decodes the symbol
//            and tracks the fixed 14-symbol frame (lock, frame and error counts).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_sequence_reader (
   input  logic                          clk,
   input  logic                          rst_n,
   seg7_sequence_reader_if.slave         bus
);

   typedef enum logic [0:0] {
      S_HUNT  = 1'b0,
      S_TRACK = 1'b1
   } state_t;

   localparam logic [3:0] c_last_idx    = 4'd13;
   localparam logic [3:0] c_sym_dp      = 4'd1;
   localparam logic [2:0] c_err_max     = 3'd7;
   localparam logic [1:0] c_settle_init = 2'd3;
   localparam logic [1:0] c_settle_cap  = 2'd2;
   localparam logic [7:0] c_uio_oe      = 8'b1111_1110;

   state_t     r_state;
   logic       r_strb_s1;
   logic       r_strb_s2;
   logic       r_strb_dly;
   logic [7:0] r_pat_s1;
   logic [7:0] r_pat_s2;
   logic [1:0] r_settle;
   logic [3:0] r_idx;
   logic [3:0] r_sym;
   logic       r_sym_valid;
   logic       r_frame_done;
   logic       r_mismatch;
   logic [3:0] r_frame_cnt;
   logic [2:0] r_err_cnt;

   logic       w_edge;
   logic       w_capture;
   logic [3:0] w_sym;
   logic [3:0] w_exp;
   logic       w_unused;

   function automatic logic [3:0] decode_sym(input logic [7:0] pat);
      case (pat)
         8'h00:   decode_sym = 4'd0;
         8'h80:   decode_sym = 4'd1;
         8'h5B:   decode_sym = 4'd2;
         8'h4F:   decode_sym = 4'd3;
         8'h15:   decode_sym = 4'd4;
         8'h7E:   decode_sym = 4'd5;
         8'h0E:   decode_sym = 4'd6;
         8'h5F:   decode_sym = 4'd7;
         8'h3E:   decode_sym = 4'd8;
         default: decode_sym = 4'hF;
      endcase
   endfunction

   // Frame "dp S E n O L G U L G O n U L" as symbol codes, indexed 0..13.
   function automatic logic [3:0] expected_sym(input logic [3:0] idx);
      case (idx)
         4'd0:    expected_sym = 4'd1;
         4'd1:    expected_sym = 4'd2;
         4'd2:    expected_sym = 4'd3;
         4'd3:    expected_sym = 4'd4;
         4'd4:    expected_sym = 4'd5;
         4'd5:    expected_sym = 4'd6;
         4'd6:    expected_sym = 4'd7;
         4'd7:    expected_sym = 4'd8;
         4'd8:    expected_sym = 4'd6;
         4'd9:    expected_sym = 4'd7;
         4'd10:   expected_sym = 4'd5;
         4'd11:   expected_sym = 4'd4;
         4'd12:   expected_sym = 4'd8;
         4'd13:   expected_sym = 4'd6;
         default: expected_sym = 4'hF;
      endcase
   endfunction

   assign w_edge    = r_strb_s2 & ~r_strb_dly;
   // Settle counter loads 3 on the edge; capture happens while it reads 2,
   // and the value 1 still blocks edges in the cycle after capture.
   assign w_capture = (r_settle == c_settle_cap);
   assign w_sym     = decode_sym(r_pat_s2);
   assign w_exp     = expected_sym(r_idx);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_HUNT;
         r_strb_s1    <= 1'b0;
         r_strb_s2    <= 1'b0;
         r_strb_dly   <= 1'b0;
         r_pat_s1     <= 8'h00;
         r_pat_s2     <= 8'h00;
         r_settle     <= 2'd0;
         r_idx        <= 4'd0;
         r_sym        <= 4'd0;
         r_sym_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         r_mismatch   <= 1'b0;
         r_frame_cnt  <= 4'd0;
         r_err_cnt    <= 3'd0;
      end else begin
         r_strb_s1    <= bus.uio_in[0];
         r_strb_s2    <= r_strb_s1;
         r_strb_dly   <= r_strb_s2;
         r_pat_s1     <= bus.ui_in;
         r_pat_s2     <= r_pat_s1;
         r_sym_valid  <= 1'b0;
         r_frame_done <= 1'b0;

         if (r_settle != 2'd0) begin
            r_settle <= r_settle - 2'd1;
         end else if (w_edge) begin
            r_settle <= c_settle_init;
         end

         if (w_capture) begin
            r_sym       <= w_sym;
            r_sym_valid <= 1'b1;
            case (r_state)
               S_HUNT: begin
                  if (w_sym == c_sym_dp) begin
                     r_state <= S_TRACK;
                     r_idx   <= 4'd1;
                  end
               end
               S_TRACK: begin
                  if (w_sym == w_exp) begin
                     if (r_idx == c_last_idx) begin
                        r_idx        <= 4'd0;
                        r_frame_cnt  <= r_frame_cnt + 4'd1;
                        r_frame_done <= 1'b1;
                     end else begin
                        r_idx <= r_idx + 4'd1;
                     end
                  end else begin
                     r_mismatch <= 1'b1;
                     if (r_err_cnt != c_err_max) begin
                        r_err_cnt <= r_err_cnt + 3'd1;
                     end
                     // A stray dp is treated as the start of a fresh frame.
                     if (w_sym == c_sym_dp) begin
                        r_state <= S_TRACK;
                        r_idx   <= 4'd1;
                     end else begin
                        r_state <= S_HUNT;
                        r_idx   <= 4'd0;
                     end
                  end
               end
               default: begin
                  r_state <= S_HUNT;
                  r_idx   <= 4'd0;
               end
            endcase
         end
      end
   end

   assign bus.uo_out  = {r_mismatch, r_sym_valid, r_frame_done,
                         (r_state == S_TRACK), r_sym};
   assign bus.uio_out = {r_err_cnt, r_frame_cnt, 1'b0};
   assign bus.uio_oe  = c_uio_oe;

   assign w_unused = &{1'b0, bus.ena, bus.uio_in[7:1]};

endmodule

`default_nettype wire

// File: tb/tb_seg7_sequence_reader.sv
// ============================================================================
// Module   : tb_seg7_sequence_reader
// Brief    : Directed bench for seg7_sequence_reader: decode, frame tracking,
//            counters, reset behaviour and strobe-rate filtering.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_sequence_reader;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] pat_tab [0:8] = '{8'h00, 8'h80, 8'h5B, 8'h4F, 8'h15,
                                 8'h7E, 8'h0E, 8'h5F, 8'h3E};
   int frame_tab [0:13] = '{1, 2, 3, 4, 5, 6, 7, 8, 6, 7, 5, 4, 8, 6};

   seg7_sequence_reader_if bus ();

   seg7_sequence_reader dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Entered and left at posedge+1; one strobe per 10 clk, high for 5 clk.
   task automatic send_sym(input logic [7:0] pat, output int nvalid, output int lat,
                           output logic [7:0] uo_v, output logic [7:0] uio_v,
                           output int nfd);
      nvalid = 0; lat = 0; nfd = 0; uo_v = 8'h00; uio_v = 8'h00;
      bus.ui_in  = pat;
      bus.uio_in = 8'h01;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (bus.uo_out[6]) begin
            nvalid++; lat = i; uo_v = bus.uo_out; uio_v = bus.uio_out;
         end
         if (bus.uo_out[5]) nfd++;
         @(posedge clk); #1;
         if (i == 5) bus.uio_in = 8'h00;
      end
   endtask

   task automatic apply_reset(input int n);
      bus.ui_in  = 8'h00;
      bus.uio_in = 8'h00;
      rst_n      = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.ui_in  = 8'($urandom);
         bus.uio_in = 8'($urandom);
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++; if (bus.uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo_out: got %h expected 00", bus.uo_out); end
      checks++; if (bus.uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio_out: got %h expected 00", bus.uio_out); end
      checks++; if (bus.uio_oe !== 8'hFE) begin errors++; $display("FAIL reset_uio_oe: got %h expected FE", bus.uio_oe); end
      apply_reset(1);
      checks++; if (bus.uio_oe !== 8'hFE) begin errors++; $display("FAIL run_uio_oe: got %h expected FE", bus.uio_oe); end
   endtask

   task automatic test_full_frame();
      int nv, lat, nfd;
      logic [7:0] uo, uio;
      apply_reset(2);
      for (int i = 0; i < 14; i++) begin
         send_sym(pat_tab[frame_tab[i]], nv, lat, uo, uio, nfd);
         checks++; if (nv !== 1) begin errors++; $display("FAIL frame_valid_cnt[%0d]: got %0d expected 1", i, nv); end
         checks++; if (lat !== 6) begin errors++; $display("FAIL frame_latency[%0d]: got %0d expected 6", i, lat); end
         checks++; if (uo[3:0] !== 4'(frame_tab[i])) begin errors++; $display("FAIL frame_code[%0d]: got %h expected %h", i, uo[3:0], frame_tab[i]); end
         checks++; if (uo[4] !== 1'b1) begin errors++; $display("FAIL frame_locked[%0d]: got %b expected 1", i, uo[4]); end
         checks++; if (nfd !== ((i == 13) ? 1 : 0)) begin errors++; $display("FAIL frame_done_cnt[%0d]: got %0d expected %0d", i, nfd, (i == 13) ? 1 : 0); end
      end
      checks++; if (bus.uio_out[4:1] !== 4'd1) begin errors++; $display("FAIL frame_count: got %0d expected 1", bus.uio_out[4:1]); end
      checks++; if (bus.uo_out[7] !== 1'b0) begin errors++; $display("FAIL frame_mismatch: got %b expected 0", bus.uo_out[7]); end
      checks++; if (bus.uio_out[7:5] !== 3'd0) begin errors++; $display("FAIL frame_err_count: got %0d expected 0", bus.uio_out[7:5]); end
   endtask

   task automatic test_mismatch();
      int nv, lat, nfd;
      logic [7:0] uo, uio;
      apply_reset(2);
      send_sym(8'h80, nv, lat, uo, uio, nfd);
      send_sym(8'h5B, nv, lat, uo, uio, nfd);
      send_sym(8'h0E, nv, lat, uo, uio, nfd);
      checks++; if (uio[7:5] !== 3'd1) begin errors++; $display("FAIL mm_err_count: got %0d expected 1", uio[7:5]); end
      checks++; if (uo[7] !== 1'b1) begin errors++; $display("FAIL mm_sticky: got %b expected 1", uo[7]); end
      checks++; if (uo[4] !== 1'b0) begin errors++; $display("FAIL mm_locked: got %b expected 0", uo[4]); end
      checks++; if (uo[3:0] !== 4'd6) begin errors++; $display("FAIL mm_code: got %h expected 6", uo[3:0]); end
      send_sym(8'h80, nv, lat, uo, uio, nfd);
      checks++; if (uo[4] !== 1'b1) begin errors++; $display("FAIL mm_relock: got %b expected 1", uo[4]); end
      send_sym(8'h5B, nv, lat, uo, uio, nfd);
      checks++; if (uo[4] !== 1'b1) begin errors++; $display("FAIL mm_idx1_locked: got %b expected 1", uo[4]); end
      checks++; if (uio[7:5] !== 3'd1) begin errors++; $display("FAIL mm_idx1_err: got %0d expected 1", uio[7:5]); end
      checks++; if (uo[7] !== 1'b1) begin errors++; $display("FAIL mm_sticky_hold: got %b expected 1", uo[7]); end
   endtask

   task automatic test_unknown();
      int nv, lat, nfd;
      logic [7:0] uo, uio;
      apply_reset(2);
      send_sym(8'h55, nv, lat, uo, uio, nfd);
      checks++; if (uo[3:0] !== 4'hF) begin errors++; $display("FAIL unk_code: got %h expected F", uo[3:0]); end
      checks++; if (uo[4] !== 1'b0) begin errors++; $display("FAIL unk_locked: got %b expected 0", uo[4]); end
      checks++; if (uio[7:5] !== 3'd0) begin errors++; $display("FAIL unk_hunt_err: got %0d expected 0", uio[7:5]); end
      send_sym(8'h00, nv, lat, uo, uio, nfd);
      checks++; if (uo[3:0] !== 4'h0) begin errors++; $display("FAIL blank_code: got %h expected 0", uo[3:0]); end
      checks++; if (nv !== 1) begin errors++; $display("FAIL blank_valid: got %0d expected 1", nv); end
      checks++; if (uo[7] !== 1'b0 || uio[7:5] !== 3'd0) begin errors++; $display("FAIL blank_no_err: got mm=%b err=%0d expected 0/0", uo[7], uio[7:5]); end
      send_sym(8'h80, nv, lat, uo, uio, nfd);
      send_sym(8'h55, nv, lat, uo, uio, nfd);
      checks++; if (uio[7:5] !== 3'd1) begin errors++; $display("FAIL unk_track_err: got %0d expected 1", uio[7:5]); end
      checks++; if (uo[4] !== 1'b0) begin errors++; $display("FAIL unk_track_hunt: got %b expected 0", uo[4]); end
      checks++; if (uo[3:0] !== 4'hF) begin errors++; $display("FAIL unk_track_code: got %h expected F", uo[3:0]); end
   endtask

   task automatic test_wrap_saturation();
      int nv, lat, nfd;
      logic [7:0] uo, uio;
      apply_reset(2);
      for (int f = 0; f < 17; f++) begin
         for (int i = 0; i < 14; i++) begin
            send_sym(pat_tab[frame_tab[i]], nv, lat, uo, uio, nfd);
            if (f == 15 && i == 13) begin
               checks++; if (uio[4:1] !== 4'd0) begin errors++; $display("FAIL wrap_16: got %0d expected 0", uio[4:1]); end
            end
         end
      end
      checks++; if (bus.uio_out[4:1] !== 4'd1) begin errors++; $display("FAIL wrap_17: got %0d expected 1", bus.uio_out[4:1]); end
      // First dp matches idx 0; each further dp is a mismatch that relocks.
      for (int k = 0; k < 10; k++) begin
         send_sym(8'h80, nv, lat, uo, uio, nfd);
         if (k == 6) begin
            checks++; if (uio[7:5] !== 3'd6) begin errors++; $display("FAIL sat_6: got %0d expected 6", uio[7:5]); end
         end
         if (k == 7) begin
            checks++; if (uio[7:5] !== 3'd7) begin errors++; $display("FAIL sat_7: got %0d expected 7", uio[7:5]); end
         end
      end
      checks++; if (uio[7:5] !== 3'd7) begin errors++; $display("FAIL sat_9: got %0d expected 7", uio[7:5]); end
      checks++; if (uo[4] !== 1'b1) begin errors++; $display("FAIL sat_locked: got %b expected 1", uo[4]); end
      checks++; if (uio[4:1] !== 4'd1) begin errors++; $display("FAIL sat_frames: got %0d expected 1", uio[4:1]); end
   endtask

   task automatic test_reset_mid_frame();
      int nv, lat, nfd;
      logic [7:0] uo, uio;
      apply_reset(2);
      for (int i = 0; i < 7; i++) send_sym(pat_tab[frame_tab[i]], nv, lat, uo, uio, nfd);
      checks++; if (uo[4] !== 1'b1) begin errors++; $display("FAIL mid_pre_locked: got %b expected 1", uo[4]); end
      apply_reset(2);
      @(negedge clk);
      checks++; if (bus.uo_out !== 8'h00) begin errors++; $display("FAIL mid_uo_out: got %h expected 00", bus.uo_out); end
      checks++; if (bus.uio_out !== 8'h00) begin errors++; $display("FAIL mid_uio_out: got %h expected 00", bus.uio_out); end
      @(posedge clk); #1;
      send_sym(8'h5B, nv, lat, uo, uio, nfd);
      checks++; if (uo[3:0] !== 4'd2) begin errors++; $display("FAIL mid_restart_code: got %h expected 2", uo[3:0]); end
      checks++; if (uo[4] !== 1'b0) begin errors++; $display("FAIL mid_restart_locked: got %b expected 0", uo[4]); end
      checks++; if (uio[7:5] !== 3'd0) begin errors++; $display("FAIL mid_restart_err: got %0d expected 0", uio[7:5]); end
      // Reset asserted on the capture edge must win.
      bus.ui_in  = 8'h80;
      bus.uio_in = 8'h01;
      repeat (4) @(posedge clk);
      #1; rst_n = 1'b0;
      @(posedge clk); #1;
      bus.uio_in = 8'h00;
      @(posedge clk); #1;
      rst_n = 1'b1;
      nv = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.uo_out !== 8'h00) nv++;
      end
      checks++; if (nv !== 0) begin errors++; $display("FAIL reset_wins_capture: got %0d nonzero cycles expected 0", nv); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int nv;
      logic [7:0] uo;
      apply_reset(2);
      nv = 0; uo = 8'h00;
      bus.ui_in  = 8'h80;
      bus.uio_in = 8'h01;
      @(posedge clk); #1;
      bus.uio_in = 8'h00;
      @(posedge clk); #1;
      bus.uio_in = 8'h01;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.uo_out[6]) begin nv++; uo = bus.uo_out; end
         @(posedge clk); #1;
         if (i == 4) bus.uio_in = 8'h00;
      end
      checks++; if (nv !== 1) begin errors++; $display("FAIL b2b_valid_cnt: got %0d expected 1", nv); end
      checks++; if (uo[3:0] !== 4'd1) begin errors++; $display("FAIL b2b_code: got %h expected 1", uo[3:0]); end
      checks++; if (uo[4] !== 1'b1) begin errors++; $display("FAIL b2b_locked: got %b expected 1", uo[4]); end
   endtask

   initial begin
      bus.ena    = 1'b1;
      bus.ui_in  = 8'h00;
      bus.uio_in = 8'h00;
      rst_n      = 1'b0;
      test_reset();
      test_full_frame();
      test_mismatch();
      test_unknown();
      test_wrap_saturation();
      test_reset_mid_frame();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/seg7_sequence_reader.md
# seg7_sequence_reader

Receive-side companion to the team's 7-segment message display. It samples the 8-bit segment bus driven by a display unit on every advance strobe and decodes each pattern back into a 4-bit symbol code. It then tracks the 14-symbol frame "dp S E n O L G U L G O n U L", reporting lock, completed frames and mismatches. It sits in the same Tiny Tapeout tile wrapper and uses the standard pin set.

## Interface
- No parameters; the frame content and symbol table are fixed.
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- ena  input  1  always 1 when powered; ignored
- ui_in  input  8  segment bus from the sender: bit7 = dp, bits6..0 = segments a..g
- uio_in  input  8  bit0 = advance strobe from the sender (asynchronous, rising-edge meaningful); bits7..1 ignored
- uo_out  output  8  [3:0] last symbol code, [4] locked, [5] frame_done pulse, [6] sym_valid pulse, [7] mismatch sticky
- uio_out  output  8  [0] = 0, [4:1] frame count, [7:5] error count
- uio_oe  output  8  constant 8'b1111_1110 (bit0 is an input)

## Operation
- Symbol decode of the exact 8-bit pattern; any other value maps to 4'hF (unknown):
  - 0x00 → 0 (blank)
  - 0x80 → 1 (dp)
  - 0x5B → 2 (S)
  - 0x4F → 3 (E)
  - 0x15 → 4 (n)
  - 0x7E → 5 (O)
  - 0x0E → 6 (L)
  - 0x5F → 7 (G)
  - 0x3E → 8 (U)
- Expected frame, index 0..13: 1,2,3,4,5,6,7,8,6,7,5,4,8,6.
- Input conditioning:
  - uio_in[0] passes through two synchronizer flops plus one delay flop.
  - ui_in passes through two flops.
  - An edge is a cycle where sync2 = 1 and delay = 0.
- States:
  - HUNT: on a captured symbol == 1 (dp), go to TRACK with idx = 1. Any other symbol stays in HUNT with no error counted.
  - TRACK, symbol == expected[idx]: idx increments. At idx 13, idx wraps to 0, frame count increments modulo 16 and frame_done pulses.
  - TRACK, symbol != expected[idx]: error count increments, saturating at 7, and mismatch sets. If the symbol is 1 (dp), go to TRACK with idx = 1; otherwise go to HUNT.
- locked = 1 exactly when the state is TRACK.
- mismatch stays set until reset.
- uo_out[3:0] holds the last decoded symbol until the next capture.
- Reset values: every uo_out and uio_out bit is 0, state = HUNT, idx = 0, both counters = 0, synchronizers = 0. uio_oe is constant through reset.
- Reset applied mid-frame discards all progress. The first capture after release must start from HUNT.

## Timing
- Edge detected in cycle E.
- Settle counter: the pattern is captured from the 2-flop pattern register at the end of cycle E+2.
- Decode, state update and all outputs are registered and visible in cycle E+3.
- Latency: 3 cycles from the detected edge to output, 5–6 clk from the raw strobe rise.
- sym_valid and frame_done are high for exactly one cycle (E+3). frame_done coincides with the sym_valid of the 14th symbol.
- Edges detected in cycles E+1..E+3 are ignored; no queuing.
- Sender requirements:
  - strobe period ≥ 6 clk
  - strobe high ≥ 3 clk
  - pattern stable from the strobe rise until ≥ 4 clk after it
- Error count saturation: a mismatch at count 7 leaves it at 7. mismatch and the state transition still apply.
- Frame count wrap: 15 + 1 → 0 with no flag.
- rst_n is sampled only on rising clk. A reset asserted in the same cycle as a capture wins and leaves the reset values.

## Test plan
- Reset: hold rst_n = 0 for 4 clk with random ui_in/uio_in → uo_out = 0x00, uio_out = 0x00, uio_oe = 0xFE.
- Full frame: drive the 14 patterns (0x80, 0x5B, …, 0x0E), one strobe per 10 clk → one sym_valid per strobe at E+3. Codes follow 1,2,3,4,5,6,7,8,6,7,5,4,8,6. locked = 1 from the first symbol. frame_done pulses once on the 14th. uio_out[4:1] = 1, mismatch = 0.
- Mismatch: dp, S, then 0x0E (L) instead of E → error count = 1, mismatch = 1, locked = 0. A following dp relocks with idx = 1.
- Unknown and leading junk: 0x55 then 0x00 in HUNT → codes F and 0, no errors, stays unlocked. 0x55 in TRACK → error count +1, HUNT.
- Wrap and saturation: 17 clean frames → frame count = 1. 9 mismatches → error count = 7.
- Reset mid-frame and strobe rate:
  - Assert rst_n = 0 at symbol 7 → all cleared. Restarting at S does not lock.
  - A second strobe edge at E+2 is ignored: exactly one sym_valid.
